shift_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its `in`, `Sel` and `load` inputs. It accepts shift commands (data, operation code, hold length) over a valid/ready handshake and buffers them in a small FIFO. Each command is issued as one load cycle followed by one or more execute cycles. Between commands the register is parked on the hold operation, so its `result` stays stable.

---
 rtl/shift_cmd_seq.sv | 151 +++++++++++++++
 tb/tb_shift_cmd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding a 4-bit universal shift register: buffers
// (data, op, hold) commands in a FIFO and issues each as LOAD + EXEC cycles.
module shift_cmd_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_data,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_hold,
    output logic [3:0]       sr_in,
    output logic [2:0]       sr_sel,
    output logic             sr_load,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENT_W = 9;
    localparam logic [2:0]  SEL_HOLD = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t           state;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push;
    logic             pop;
    logic             cmd_done;
    logic [ENT_W-1:0] head;
    logic [3:0]       cur_data;
    logic [2:0]       cur_op;
    logic [1:0]       cur_hold;
    logic [1:0]       hcnt;

    // Handshake, pop decision and occupancy update
    always_comb begin
        push      = cmd_valid && cmd_ready;
        cmd_done  = (state == EXEC) && (hcnt == 2'd0);
        pop       = (count != '0) && ((state == IDLE) || cmd_done);
        head      = mem[rd_ptr];
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_data, cmd_op, cmd_hold};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            cmd_ready <= count_nxt < (AW+1)'(DEPTH);
        end
    end

    // Sequencer FSM with registered shift-register drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_data <= '0;
            cur_op   <= '0;
            cur_hold <= '0;
            hcnt     <= '0;
            sr_in    <= '0;
            sr_sel   <= SEL_HOLD;
            sr_load  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (cmd_done) begin
                done     <= 1'b1;
                done_cnt <= done_cnt + 1'b1;
            end
            if (pop) begin
                state    <= LOAD;
                cur_data <= head[8:5];
                cur_op   <= head[4:2];
                cur_hold <= head[1:0];
                sr_load  <= 1'b1;
                sr_in    <= head[8:5];
                sr_sel   <= SEL_HOLD;
                busy     <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        state   <= EXEC;
                        hcnt    <= cur_hold;
                        sr_load <= 1'b0;
                        sr_in   <= cur_data;
                        sr_sel  <= cur_op;
                        busy    <= 1'b1;
                    end
                    EXEC: begin
                        if (cmd_done) begin
                            state   <= IDLE;
                            sr_load <= 1'b0;
                            sr_in   <= '0;
                            sr_sel  <= SEL_HOLD;
                            busy    <= 1'b0;
                        end else begin
                            hcnt <= hcnt - 1'b1;
                        end
                    end
                    IDLE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        sr_load <= 1'b0;
                        sr_in   <= '0;
                        sr_sel  <= SEL_HOLD;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Scoreboard bench for shift_cmd_seq: a timeline model predicts the pop edge of
// every accepted command; a monitor compares the DUT outputs every cycle.
module tb_shift_cmd_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_data = '0;
    logic [2:0]       cmd_op = '0;
    logic [1:0]       cmd_hold = '0;
    logic [3:0]       sr_in;
    logic [2:0]       sr_sel;
    logic             sr_load;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] done_cnt;

    shift_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_op(cmd_op), .cmd_hold(cmd_hold),
        .sr_in(sr_in), .sr_sel(sr_sel), .sr_load(sr_load),
        .busy(busy), .done(done), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         p;
        int         hold;
        logic [3:0] data;
        logic [2:0] op;
        int         cnt;
    } cmd_t;

    cmd_t expq[$];
    int   acc_e[$];
    int   pop_e[$];
    int   free_edge = 0;
    int   total = 0;

    bit         act = 1'b0;
    int         act_p = 0;
    int         act_end = 0;
    logic [3:0] act_data = '0;
    logic [2:0] act_op = '0;
    int         done_edge = -1;
    int         done_val = 0;
    int         exp_cnt = 0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Commands still waiting in the FIFO after edge n
    function automatic int occ(input int n);
        int c = 0;
        foreach (acc_e[i]) begin
            if (acc_e[i] <= n) c++;
            if (pop_e[i] <= n) c--;
        end
        return c;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sr_in"}, 32'(sr_in), 32'd0);
        chk({tag, "_sr_sel"}, 32'(sr_sel), 32'd3);
        chk({tag, "_sr_load"}, 32'(sr_load), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Called just after an edge; drives inputs for the next edge
    task automatic send(input bit v, input logic [3:0] d, input logic [2:0] o, input logic [1:0] h);
        cmd_t c;
        cmd_valid = v;
        cmd_data  = d;
        cmd_op    = o;
        cmd_hold  = h;
        if (v && occ(cyc) < DEPTH) begin
            c.p    = (cyc + 2 > free_edge) ? cyc + 2 : free_edge;
            c.hold = int'(h);
            c.data = d;
            c.op   = o;
            total++;
            c.cnt  = total;
            free_edge = c.p + 2 + c.hold;
            expq.push_back(c);
            acc_e.push_back(cyc + 1);
            pop_e.push_back(c.p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 4'd0, 3'd0, 2'd0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        expq.delete();
        acc_e.delete();
        pop_e.delete();
        free_edge = 0;
        total     = 0;
        act       = 1'b0;
        done_edge = -1;
        exp_cnt   = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compare every cycle against the predicted timeline
    initial begin
        cmd_t c;
        int   n;
        bit   exp_done;
        forever begin
            @(negedge clk);
            n = cyc;
            if (rst) begin
                check_reset_vals("in_rst");
            end else begin
                exp_done = (n == done_edge);
                if (exp_done) exp_cnt = done_val;
                if (expq.size() > 0 && expq[0].p == n) begin
                    c         = expq.pop_front();
                    act       = 1'b1;
                    act_p     = n;
                    act_end   = n + 1 + c.hold;
                    act_data  = c.data;
                    act_op    = c.op;
                    done_edge = n + 2 + c.hold;
                    done_val  = c.cnt % (1 << CNT_W);
                end
                if (act && n == act_p) begin
                    chk("load_sr_load", 32'(sr_load), 32'd1);
                    chk("load_sr_in", 32'(sr_in), 32'(act_data));
                    chk("load_sr_sel", 32'(sr_sel), 32'd3);
                    chk("load_busy", 32'(busy), 32'd1);
                end else if (act && n <= act_end) begin
                    chk("exec_sr_load", 32'(sr_load), 32'd0);
                    chk("exec_sr_in", 32'(sr_in), 32'(act_data));
                    chk("exec_sr_sel", 32'(sr_sel), 32'(act_op));
                    chk("exec_busy", 32'(busy), 32'd1);
                end else begin
                    act = 1'b0;
                    chk("idle_sr_load", 32'(sr_load), 32'd0);
                    chk("idle_sr_in", 32'(sr_in), 32'd0);
                    chk("idle_sr_sel", 32'(sr_sel), 32'd3);
                    chk("idle_busy", 32'(busy), 32'd0);
                end
                chk("done", 32'(done), 32'(exp_done));
                chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
                chk("cmd_ready", 32'(cmd_ready), 32'(occ(n) < DEPTH));
            end
        end
    end

    // Stimulus
    initial begin
        #1 rst = 1'b1;
        #2 check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(1'b1, 4'b1011, 3'b110, 2'd0);
        idle(6);
        send(1'b1, 4'b0110, 3'b010, 2'd3);
        idle(9);

        // Overfill: extra valids while full must be dropped
        repeat (DEPTH + 3) send(1'b1, 4'($urandom()), 3'($urandom()), 2'd3);
        idle(30);

        // Single entry queued, second pushed on the pop edge
        send(1'b1, 4'd5, 3'd1, 2'd1);
        send(1'b1, 4'd9, 3'd4, 2'd0);
        idle(10);

        // Reset in EXEC with two commands still queued
        repeat (3) send(1'b1, 4'($urandom()), 3'($urandom()), 2'd3);
        idle(2);
        do_reset();
        idle(8);

        // Counter wrap with CNT_W=2
        repeat (5) send(1'b1, 4'($urandom()), 3'($urandom()), 2'd0);
        idle(15);

        for (int i = 0; i < 400; i++)
            send(($urandom() % 3) != 0, 4'($urandom()), 3'($urandom()), 2'($urandom()));
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
